// File: rtl/pico_mem_pkg.sv
// ---------------------------------------------------------------------------
// pico_mem_pkg
// Shared types and defaults for the picorv32 native-bus memory responder.
//   state_e              : responder FSM states (IDLE / WAIT / RESP)
//   WSTRB_READ           : strobe pattern that marks a read request
//   FAULT_RDATA_DEFAULT  : data returned on a faulting read or fetch
//   EXEC_LIMIT_DEFAULT   : first word index where instruction fetches fault
//   WORDS_DEFAULT        : default SRAM depth in 32-bit words
// ---------------------------------------------------------------------------
package pico_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0]  WSTRB_READ          = 4'b0000;
  localparam logic [31:0] FAULT_RDATA_DEFAULT = 32'h0000_0000;
  localparam int          EXEC_LIMIT_DEFAULT  = 768;
  localparam int          WORDS_DEFAULT       = 1024;

endpackage

// File: rtl/mem_bus_responder_if.sv
// ---------------------------------------------------------------------------
// mem_bus_responder_if
// picorv32 native memory bus bundle.
//   mem_valid  : request valid            (master -> slave)
//   mem_instr  : request is a fetch       (master -> slave)
//   mem_addr   : byte address             (master -> slave)
//   mem_wdata  : write data               (master -> slave)
//   mem_wstrb  : byte enables, 0 = read   (master -> slave)
//   mem_ready  : one-cycle response       (slave -> master)
//   mem_rdata  : read data                (slave -> master)
// ---------------------------------------------------------------------------
interface mem_bus_responder_if;

  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_resp_array.sv
// ---------------------------------------------------------------------------
// mem_resp_array
// Single-port WORDS x 32 SRAM with per-byte write enables and a registered
// read port (maps onto block RAM). The storage array is named "mem" so it
// can be preloaded hierarchically.
//   clk      : clock
//   addr_i   : word address (shared by read and write)
//   re_i     : read enable; rdata_o updates on the next edge
//   be_i     : byte write enables, bit i writes wdata_i[8*i+7:8*i]
//   wdata_i  : write data
//   rdata_o  : registered read data
// ---------------------------------------------------------------------------
module mem_resp_array #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic          re_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) begin
        mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// ---------------------------------------------------------------------------
// mem_bus_responder
// Slave end of the picorv32 native memory bus, backed by an internal SRAM.
// Adds WAIT_STATES extra cycles before mem_ready, byte-strobe writes,
// out-of-range detection and execute protection for words >= EXEC_LIMIT.
//   clk          : clock
//   reset        : synchronous active-high reset
//   bus          : native memory bus (slave modport)
//   fault        : one-cycle pulse with mem_ready of a faulting access
//   fault_addr   : sticky byte address of the most recent fault
//   fault_instr  : sticky, 1 if the most recent fault was a fetch
// Latency: mem_valid seen in cycle N -> mem_ready in cycle N+1+WAIT_STATES.
// ---------------------------------------------------------------------------
module mem_bus_responder
  import pico_mem_pkg::*;
#(
  parameter int          WORDS       = WORDS_DEFAULT,
  parameter int          WAIT_STATES = 1,
  parameter int          EXEC_LIMIT  = EXEC_LIMIT_DEFAULT,
  parameter logic [31:0] FAULT_RDATA = FAULT_RDATA_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_bus_responder_if.slave   bus,
  output logic                 fault,
  output logic [31:0]          fault_addr,
  output logic                 fault_instr
);

  localparam int AW = $clog2(WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        instr_q, instr_d;
  logic [31:0] hold_q;
  logic [31:0] fault_addr_q;
  logic        fault_instr_q;

  logic          resp_active;
  logic          out_of_range;
  logic          exec_violation;
  logic          fault_now;
  logic          is_write;
  logic [31:0]   resp_data;
  logic [31:0]   arr_rdata;
  logic [AW-1:0] arr_addr;
  logic          arr_re;
  logic [3:0]    arr_be;

  // Byte offset bits are don't-care on this word-oriented bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.mem_addr[1:0];

  // Full 30-bit compare so addresses beyond the array never alias into it.
  assign out_of_range   = {2'b00, idx_q} >= 32'(WORDS);
  assign exec_violation = instr_q && ({2'b00, idx_q} >= 32'(EXEC_LIMIT));
  assign fault_now      = out_of_range || exec_violation;
  assign is_write       = wstrb_q != WSTRB_READ;

  // Reset wins over a response already in flight: no ready, no fault.
  assign resp_active = (state_q == RESP) && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_valid) begin
          idx_d   = bus.mem_addr[31:2];
          wdata_d = bus.mem_wdata;
          wstrb_d = bus.mem_wstrb;
          instr_d = bus.mem_instr;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // With zero wait states the array is read on the accepting edge, before
  // the request has been latched, so the live bus address is used there.
  assign arr_addr = (state_q == IDLE) ? bus.mem_addr[AW+1:2] : idx_q[AW-1:0];
  assign arr_re   = (state_q != RESP) && (state_d == RESP);
  assign arr_be   = (resp_active && !fault_now) ? wstrb_q : WSTRB_READ;

  mem_resp_array #(
    .WORDS (WORDS)
  ) u_array (
    .clk     (clk),
    .addr_i  (arr_addr),
    .re_i    (arr_re),
    .be_i    (arr_be),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    resp_data = arr_rdata;
    if (fault_now) begin
      resp_data = FAULT_RDATA;
    end else if (is_write) begin
      resp_data = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      hold_q        <= 32'h0;
      fault_addr_q  <= 32'h0;
      fault_instr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (resp_active) begin
        hold_q <= resp_data;
      end
      if (resp_active && fault_now) begin
        fault_addr_q  <= {idx_q, 2'b00};
        fault_instr_q <= instr_q;
      end
    end
  end

  // Request latches carry no reset; they are only consumed after IDLE loads them.
  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
    instr_q <= instr_d;
  end

  // Response data is shown live in RESP and held afterwards.
  assign bus.mem_ready = resp_active;
  assign bus.mem_rdata = resp_active ? resp_data : hold_q;
  assign fault         = resp_active && fault_now;
  assign fault_addr    = fault_addr_q;
  assign fault_instr   = fault_instr_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_responder
// Table-driven bench for mem_bus_responder: dut1 (WAIT_STATES=1) runs the
// vector table plus reset-abort sequence, dut0 (WAIT_STATES=0) runs a
// back-to-back sequence. Responses are checked against scoreboard queues.
// ---------------------------------------------------------------------------
module tb_mem_bus_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          id;
  } exp_t;

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    logic [31:0] exp_faddr;
    logic        exp_finstr;
    logic        drop;
  } vec_t;

  localparam int NVEC = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_responder_if bus1();
  mem_bus_responder_if bus0();

  logic        fault1, fault0;
  logic [31:0] faddr1, faddr0;
  logic        finstr1, finstr0;

  mem_bus_responder #(
    .WORDS(1024), .WAIT_STATES(1), .EXEC_LIMIT(768), .FAULT_RDATA(32'h0)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .fault(fault1), .fault_addr(faddr1), .fault_instr(finstr1)
  );

  mem_bus_responder #(
    .WORDS(1024), .WAIT_STATES(0), .EXEC_LIMIT(768), .FAULT_RDATA(32'h0)
  ) dut0 (
    .clk(clk), .reset(reset), .bus(bus0),
    .fault(fault0), .fault_addr(faddr0), .fault_instr(finstr0)
  );

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb1[$];
  exp_t sb0[$];
  vec_t tbl[NVEC];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop one expectation per mem_ready pulse.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (bus1.mem_ready) begin
      if (sb1.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dut1_unexpected_ready: got ready=1 expected no response");
      end else begin
        e = sb1.pop_front();
        $display("dut1 txn id=%0d rdata=%h fault=%b", e.id, bus1.mem_rdata, fault1);
        check32($sformatf("dut1_rdata_id%0d", e.id), bus1.mem_rdata, e.rdata);
        check32($sformatf("dut1_fault_id%0d", e.id), {31'b0, fault1}, {31'b0, e.fault});
      end
    end else if (fault1) begin
      n_fail++;
      $display("FAIL dut1_stray_fault: got fault=1 expected 0 outside response");
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (bus0.mem_ready) begin
      if (sb0.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dut0_unexpected_ready: got ready=1 expected no response");
      end else begin
        e = sb0.pop_front();
        $display("dut0 txn id=%0d rdata=%h fault=%b", e.id, bus0.mem_rdata, fault0);
        check32($sformatf("dut0_rdata_id%0d", e.id), bus0.mem_rdata, e.rdata);
        check32($sformatf("dut0_fault_id%0d", e.id), {31'b0, fault0}, {31'b0, e.fault});
      end
    end
  end

  // One access on dut1; returns at the negedge of the response cycle.
  task automatic access(input vec_t v, input int id);
    int   lat;
    exp_t e;
    e.rdata = v.exp_rdata;
    e.fault = v.exp_fault;
    e.id    = id;
    sb1.push_back(e);
    @(posedge clk);
    #1;
    bus1.mem_valid = 1'b1;
    bus1.mem_instr = v.instr;
    bus1.mem_addr  = v.addr;
    bus1.mem_wdata = v.wdata;
    bus1.mem_wstrb = v.wstrb;
    lat = 0;
    @(negedge clk);
    while (!bus1.mem_ready && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        // Request is latched by now; garbage on the bus must be ignored.
        bus1.mem_addr  = ~v.addr;
        bus1.mem_wdata = ~v.wdata;
        bus1.mem_wstrb = ~v.wstrb;
        if (v.drop) bus1.mem_valid = 1'b0;
      end
    end
    check32($sformatf("dut1_latency_id%0d", id), 32'(lat), 32'd2);
    bus1.mem_valid = 1'b0;
    bus1.mem_wstrb = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000ns");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] vals [3];
    exp_t        e;

    //          instr  addr           wdata          wstrb    rdata          flt   faddr          fi    drop
    tbl[0]  = '{1'b0, 32'h0000_000C, 32'h1234_5678, 4'hF,    32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
    tbl[1]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0,    32'h1234_5678, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0010, 32'h1122_3344, 4'hF,    32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
    tbl[3]  = '{1'b0, 32'h0000_0010, 32'hAABB_CCDD, 4'b0101, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0,    32'h11BB_33DD, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[5]  = '{1'b0, 32'h0000_0C00, 32'hDEAD_BEEF, 4'hF,    32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
    tbl[6]  = '{1'b1, 32'h0000_0C00, 32'h0,         4'h0,    32'h0,         1'b1, 32'h0000_0C00, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 32'h0000_0C00, 32'h0,         4'h0,    32'hDEAD_BEEF, 1'b0, 32'h0000_0C00, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 32'h0000_0000, 32'hCAFE_F00D, 4'hF,    32'h0,         1'b0, 32'h0000_0C00, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 32'h0000_1000, 32'h5555_5555, 4'hF,    32'h0,         1'b1, 32'h0000_1000, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0,    32'hCAFE_F00D, 1'b0, 32'h0000_1000, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 32'h0000_0C00, 32'h0,         4'h0,    32'hDEAD_BEEF, 1'b0, 32'h0000_1000, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 32'h0000_0BFC, 32'h7777_8888, 4'hF,    32'h0,         1'b0, 32'h0000_1000, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 32'h0000_0BFC, 32'h0,         4'h0,    32'h7777_8888, 1'b0, 32'h0000_1000, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0,    32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 32'h0000_1000, 32'h0,         4'h0,    32'h0,         1'b1, 32'h0000_1000, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 32'h0000_000C, 32'hEE00_0000, 4'b1000, 32'h0,         1'b0, 32'h0000_1000, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 32'h0000_000C, 32'h0,         4'h0,    32'hEE34_5678, 1'b0, 32'h0000_1000, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 32'h0000_0014, 32'h5555_AAAA, 4'hF,    32'h0,         1'b0, 32'h0000_1000, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 32'h0000_400C, 32'h0,         4'h0,    32'h0,         1'b1, 32'h0000_400C, 1'b0, 1'b0};

    reset = 1'b1;
    bus1.mem_valid = 1'b0; bus1.mem_instr = 1'b0; bus1.mem_addr = 32'h0;
    bus1.mem_wdata = 32'h0; bus1.mem_wstrb = 4'h0;
    bus0.mem_valid = 1'b0; bus0.mem_instr = 1'b0; bus0.mem_addr = 32'h0;
    bus0.mem_wdata = 32'h0; bus0.mem_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check32("reset_ready",  {31'b0, bus1.mem_ready}, 32'h0);
    check32("reset_rdata",  bus1.mem_rdata,          32'h0);
    check32("reset_fault",  {31'b0, fault1},         32'h0);
    check32("reset_faddr",  faddr1,                  32'h0);
    check32("reset_finstr", {31'b0, finstr1},        32'h0);

    for (int i = 0; i < NVEC; i++) begin
      access(tbl[i], i);
      @(negedge clk);
      check32($sformatf("hold_ready_v%0d", i),  {31'b0, bus1.mem_ready}, 32'h0);
      check32($sformatf("hold_rdata_v%0d", i),  bus1.mem_rdata,          tbl[i].exp_rdata);
      check32($sformatf("faddr_v%0d", i),       faddr1,                  tbl[i].exp_faddr);
      check32($sformatf("finstr_v%0d", i),      {31'b0, finstr1},        {31'b0, tbl[i].exp_finstr});
    end

    // Reset in the WAIT cycle of a write to word 5: aborted, nothing committed.
    @(posedge clk);
    #1;
    bus1.mem_valid = 1'b1; bus1.mem_instr = 1'b0; bus1.mem_addr = 32'h0000_0014;
    bus1.mem_wdata = 32'hFFFF_FFFF; bus1.mem_wstrb = 4'hF;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus1.mem_valid = 1'b0;
    bus1.mem_wstrb = 4'h0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check32("abort_ready",  {31'b0, bus1.mem_ready}, 32'h0);
    check32("abort_rdata",  bus1.mem_rdata,          32'h0);
    check32("abort_fault",  {31'b0, fault1},         32'h0);
    check32("abort_faddr",  faddr1,                  32'h0);
    check32("abort_finstr", {31'b0, finstr1},        32'h0);
    access('{1'b0, 32'h0000_0014, 32'h0, 4'h0, 32'h5555_AAAA, 1'b0, 32'h0, 1'b0, 1'b0}, 50);
    @(negedge clk);
    check32("after_abort_hold", bus1.mem_rdata, 32'h5555_AAAA);

    // Back-to-back on dut0 with mem_valid held high throughout.
    vals[0] = 32'hA0A0_A0A0;
    vals[1] = 32'hB1B1_B1B1;
    vals[2] = 32'hC2C2_C2C2;
    for (int k = 0; k < 6; k++) begin
      e.rdata = (k < 3) ? 32'h0 : vals[k-3];
      e.fault = 1'b0;
      e.id    = 100 + k;
      sb0.push_back(e);
      @(posedge clk);
      #1;
      bus0.mem_valid = 1'b1;
      bus0.mem_instr = 1'b0;
      bus0.mem_addr  = 32'((k % 3) * 4);
      bus0.mem_wdata = (k < 3) ? vals[k] : 32'h0;
      bus0.mem_wstrb = (k < 3) ? 4'hF : 4'h0;
      @(negedge clk);
      check32($sformatf("b2b_idle_k%0d", k), {31'b0, bus0.mem_ready}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      check32($sformatf("b2b_ready_k%0d", k), {31'b0, bus0.mem_ready}, 32'h1);
    end
    @(posedge clk);
    #1 bus0.mem_valid = 1'b0;

    repeat (3) @(negedge clk);
    check32("sb1_drained", 32'(sb1.size()), 32'h0);
    check32("sb0_drained", 32'(sb0.size()), 32'h0);
    check32("dut0_faddr",  faddr0,           32'h0);
    check32("dut0_finstr", {31'b0, finstr0}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
